// File: rtl/data_pair_checker.sv
`default_nettype none
// data_pair_checker -- checks data2 == data1+1 and sample spacing over a window of samples.
// Rev 1.0 -- initial release.
module data_pair_checker #(
  parameter int EXP_PERIOD = 10,
  parameter int WINDOW     = 64,
  parameter int MAX_ERR    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sample_valid,
  input  logic [7:0]  data1,
  input  logic [7:0]  data2,
  output logic        mismatch,
  output logic        period_err,
  output logic [15:0] sample_cnt,
  output logic [15:0] err_cnt,
  output logic        busy,
  output logic        done,
  output logic        pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [15:0] EXP_PERIOD_C = 16'(EXP_PERIOD);
  localparam logic [15:0] TIMEOUT_C    = 16'(4 * EXP_PERIOD);
  localparam logic [15:0] WINDOW_C     = 16'(WINDOW);
  localparam logic [15:0] MAX_ERR_C    = 16'(MAX_ERR);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state;
  logic [15:0] interval;

  logic [7:0]  data1_inc;
  logic        pair_bad;
  logic        spacing_bad;
  logic [15:0] interval_inc;
  logic [15:0] sample_next;
  logic [15:0] err_cnt_inc;
  logic [15:0] err_next;
  logic        window_hit;
  logic        err_hit;
  logic        timeout_hit;

  always_comb begin
    data1_inc    = data1 + 8'd1;
    pair_bad     = (data2 != data1_inc);
    interval_inc = sat_inc(interval);
    // The first sample of a run (taken in ARM) has no predecessor to measure against.
    spacing_bad  = (state == RUN) && (interval_inc != EXP_PERIOD_C);
    sample_next  = sat_inc(sample_cnt);
    err_cnt_inc  = sat_inc(err_cnt);
    err_next     = (pair_bad || spacing_bad) ? err_cnt_inc : err_cnt;
    window_hit   = (sample_next >= WINDOW_C);
    err_hit      = (err_next >= MAX_ERR_C);
    timeout_hit  = (state == RUN) && !sample_valid && (interval_inc == TIMEOUT_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      interval   <= 16'd0;
      mismatch   <= 1'b0;
      period_err <= 1'b0;
      sample_cnt <= 16'd0;
      err_cnt    <= 16'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      mismatch   <= 1'b0;
      period_err <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ARM;
            busy       <= 1'b1;
            sample_cnt <= 16'd0;
            err_cnt    <= 16'd0;
            pass       <= 1'b0;
            interval   <= 16'd0;
          end
        end
        ARM, RUN: begin
          if (sample_valid) begin
            interval   <= 16'd0;
            sample_cnt <= sample_next;
            err_cnt    <= err_next;
            mismatch   <= pair_bad;
            period_err <= spacing_bad;
            if (err_hit || window_hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= window_hit && !err_hit && (err_next == 16'd0);
            end else begin
              state <= RUN;
            end
          end else begin
            interval <= interval_inc;
            if (timeout_hit) begin
              period_err <= 1'b1;
              err_cnt    <= err_cnt_inc;
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
